// File: rtl/remote_latency_pipe.sv
// remote_latency_pipe: multi-channel fixed-latency elastic pipeline for
// remote-group TCDM traffic. Each channel has a non-stalling delay line
// feeding an output FIFO, and credits that bound the beats in flight so the
// FIFO can never overflow.
// Optional feature: define REMOTE_PIPE_STATS_EN to add per-channel
// saturating output-stall counters on stall_cnt_o.
module remote_latency_pipe #(
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned LatencyCycles = 7,
  parameter int unsigned FifoDepth     = LatencyCycles + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NumChannels-1:0]           in_valid_i,
  output logic [NumChannels-1:0]           in_ready_o,
  input  logic [NumChannels*DataWidth-1:0] in_data_i,
  output logic [NumChannels-1:0]           out_valid_o,
  input  logic [NumChannels-1:0]           out_ready_i,
  output logic [NumChannels*DataWidth-1:0] out_data_o,
  output logic                             idle_o
`ifdef REMOTE_PIPE_STATS_EN
  ,
  output logic [NumChannels*32-1:0]        stall_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  logic [NumChannels-1:0] cred_full;

  // Pipeline is idle only when every channel holds all of its credits
  assign idle_o = &cred_full;

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [DataWidth-1:0] din;
    logic                 accept;
    logic                 pop;
    logic                 fifo_wr;
    logic [DataWidth-1:0] fifo_wdata;
    logic [CntW-1:0]      credits;
    logic [CntW-1:0]      count;
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW-1:0]      wr_ptr;
    logic [DataWidth-1:0] mem [FifoDepth];

    assign din            = in_data_i[c*DataWidth +: DataWidth];
    assign in_ready_o[c]  = (credits != '0) && !flush_i;
    assign accept         = in_valid_i[c] && in_ready_o[c];
    assign pop            = out_valid_o[c] && out_ready_i[c];
    assign out_valid_o[c] = (count != '0);
    assign out_data_o[c*DataWidth +: DataWidth] = mem[rd_ptr];
    assign cred_full[c]   = (credits == CntW'(FifoDepth));

    // Delay line: the FIFO write register is the final latency stage, so
    // only LatencyCycles-1 explicit stages are needed ahead of it
    if (LatencyCycles > 1) begin : g_dl
      localparam int unsigned Stages = LatencyCycles - 1;
      logic [Stages-1:0]    dl_valid;
      logic [DataWidth-1:0] dl_data [Stages];

      // Valid bits shift every cycle; flush and reset discard them
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          dl_valid <= '0;
        end else if (flush_i) begin
          dl_valid <= '0;
        end else begin
          dl_valid[0] <= accept;
          for (int unsigned i = 1; i < Stages; i++) begin
            dl_valid[i] <= dl_valid[i-1];
          end
        end
      end

      // Payload shifts alongside the valid bits; qualified by them
      always_ff @(posedge clk_i) begin
        dl_data[0] <= din;
        for (int unsigned i = 1; i < Stages; i++) begin
          dl_data[i] <= dl_data[i-1];
        end
      end

      assign fifo_wr    = dl_valid[Stages-1];
      assign fifo_wdata = dl_data[Stages-1];
    end else begin : g_nodl
      assign fifo_wr    = accept;
      assign fifo_wdata = din;
    end

    // Credit counter: accept consumes, pop returns, flush restores
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        credits <= CntW'(FifoDepth);
      end else if (flush_i) begin
        credits <= CntW'(FifoDepth);
      end else if (accept && !pop) begin
        credits <= credits - CntW'(1);
      end else if (pop && !accept) begin
        credits <= credits + CntW'(1);
      end
    end

    // FIFO pointers and occupancy; pointers wrap modulo FifoDepth
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (fifo_wr) begin
          wr_ptr <= (wr_ptr == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr + PtrW'(1);
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr + PtrW'(1);
        end
        count <= count + CntW'(fifo_wr) - CntW'(pop);
      end
    end

    // FIFO storage; cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < FifoDepth; i++) begin
          mem[i] <= '0;
        end
      end else if (fifo_wr && !flush_i) begin
        mem[wr_ptr] <= fifo_wdata;
      end
    end

`ifdef REMOTE_PIPE_STATS_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles where the head is offered but not taken
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stall_cnt <= '0;
      end else if (flush_i) begin
        stall_cnt <= '0;
      end else if (out_valid_o[c] && !out_ready_i[c] && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end

    assign stall_cnt_o[c*32 +: 32] = stall_cnt;
`endif

    // Credit accounting must never wrap
    a_credit_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(accept && !pop && (credits == '0)));
    a_credit_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(pop && !accept && (credits == CntW'(FifoDepth))));
    // Credits bound the in-flight beats, so a delay-line write never meets a full FIFO
    a_fifo_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(fifo_wr && (count == CntW'(FifoDepth))));
  end

endmodule

// File: tb/tb_remote_latency_pipe.sv
// Self-checking bench for remote_latency_pipe: a queue-level model of the
// channels (accepted-but-not-popped beats with their acceptance cycle) is
// compared against the DUT every cycle, plus directed literal checks.
module tb_remote_latency_pipe;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int L  = 7;
  localparam int FD = 8;
  localparam int MQ = 8192;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [NC-1:0]    in_valid = '0;
  logic [NC-1:0]    in_ready;
  logic [NC*DW-1:0] in_data = '0;
  logic [NC-1:0]    out_valid;
  logic [NC-1:0]    out_ready = '0;
  logic [NC*DW-1:0] out_data;
  logic             idle;
`ifdef REMOTE_PIPE_STATS_EN
  logic [NC*32-1:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: per-channel list of in-flight beats
  logic [DW-1:0] m_data [NC][MQ];
  int            m_time [NC][MQ];
  int            m_head [NC];
  int            m_tail [NC];
  longint        m_stall [NC];
  int            cyc = 0;
  int            dut_accs [NC];
  int            dut_pops [NC];
  int            rst_pulses = 0;
  int            rst_seen = 0;

  always #5 clk = ~clk;

  remote_latency_pipe #(
    .NumChannels(NC), .DataWidth(DW), .LatencyCycles(L), .FifoDepth(FD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .idle_o(idle)
`ifdef REMOTE_PIPE_STATS_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_head[c]  = m_tail[c];
      m_stall[c] = 0;
    end
  endtask

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    automatic int     n;
    automatic logic   ev;
    automatic logic   er;
    automatic logic   all_empty;
    if (rst_seen != rst_pulses) begin
      rst_seen = rst_pulses;
      model_clear();
    end
    if (rst) begin
      model_clear();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data_zero", 64'(out_data == '0), 64'd1);
      chk("rst_in_ready", 64'(in_ready), 64'hF);
      chk("rst_idle", 64'(idle), 64'd1);
    end else begin
      all_empty = 1'b1;
      for (int c = 0; c < NC; c++) begin
        n  = m_tail[c] - m_head[c];
        ev = (n > 0) && (m_time[c][m_head[c] % MQ] + L <= cyc);
        er = (n < FD) && !flush;
        if (n > 0) all_empty = 1'b0;
        chk($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(ev));
        chk($sformatf("in_ready[%0d]", c), 64'(in_ready[c]), 64'(er));
        if (ev) chk($sformatf("out_data[%0d]", c), 64'(out_data[c*DW +: DW]),
                    64'(m_data[c][m_head[c] % MQ]));
`ifdef REMOTE_PIPE_STATS_EN
        chk($sformatf("stall_cnt[%0d]", c), 64'(stall_cnt[c*32 +: 32]), 64'(m_stall[c]));
        if (flush) m_stall[c] = 0;
        else if (ev && !out_ready[c] && m_stall[c] < 64'hFFFF_FFFF) m_stall[c]++;
`endif
        if (out_valid[c] && out_ready[c]) dut_pops[c]++;
        if (in_valid[c] && in_ready[c]) dut_accs[c]++;
        if (ev && out_ready[c]) m_head[c]++;
        if (in_valid[c] && er) begin
          m_data[c][m_tail[c] % MQ] = in_data[c*DW +: DW];
          m_time[c][m_tail[c] % MQ] = cyc;
          m_tail[c]++;
        end
      end
      chk("idle", 64'(idle), 64'(all_empty));
      if (flush) for (int c = 0; c < NC; c++) m_head[c] = m_tail[c];
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat on channel c: valid exactly L cycles later for one cycle
  task automatic lat_check(input int c, input logic [DW-1:0] d);
    logic [NC-1:0] onehot;
    onehot = '0;
    onehot[c] = 1'b1;
    in_valid = onehot;
    in_data[c*DW +: DW] = d;
    tick();
    in_valid = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("lat_valid", 64'(out_valid), (k == L) ? 64'(onehot) : 64'd0);
      if (k == L) begin
        chk("lat_data", 64'(out_data[c*DW +: DW]), 64'(d));
        chk("lat_idle_busy", 64'(idle), 64'd0);
      end
      if (k == 8) chk("lat_idle_after_pop", 64'(idle), 64'd1);
      tick();
    end
  endtask

  initial begin
    int base;
    logic seen;
    for (int c = 0; c < NC; c++) begin
      m_head[c] = 0; m_tail[c] = 0; m_stall[c] = 0;
      dut_accs[c] = 0; dut_pops[c] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'(idle), 64'd1);
    chk("post_rst_ready", 64'(in_ready), 64'hF);
    tick();

    // Single beat
    out_ready = '1;
    lat_check(0, 32'hDEAD_BEEF);

    // Back-to-back throughput on all channels
    in_valid = '1;
    for (int i = 0; i < 100; i++) begin
      for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = DW'(i);
      @(negedge clk);
      chk("tput_ready", 64'(in_ready), 64'hF);
      tick();
    end
    in_valid = '0;
    repeat (10) tick();
    for (int c = 0; c < NC; c++) chk("tput_pops", 64'(dut_pops[c] - 1 * (c == 0)), 64'd100);

    // Backpressure on channel 2
    out_ready = 4'b1011;
    base = dut_accs[2];
    in_valid = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      in_data[2*DW +: DW] = DW'(200 + i);
      tick();
    end
    @(negedge clk);
    chk("bp_accepted", 64'(dut_accs[2] - base), 64'd8);
    chk("bp_ready_low", 64'(in_ready[2]), 64'd0);
    tick();
    in_valid = '0;
    out_ready = '1;
    base = dut_pops[2];
    @(negedge clk);
    chk("bp_first_pop_valid", 64'(out_valid[2]), 64'd1);
    chk("bp_first_pop_data", 64'(out_data[2*DW +: DW]), 64'd200);
    chk("bp_ready_still_low", 64'(in_ready[2]), 64'd0);
    tick();
    @(negedge clk);
    chk("bp_ready_rise", 64'(in_ready[2]), 64'd1);
    repeat (10) tick();
    chk("bp_drained", 64'(dut_pops[2] - base), 64'd8);

    // Flush with 5 beats in flight on channel 1
    base = dut_pops[1];
    in_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      in_data[1*DW +: DW] = DW'(500 + i);
      tick();
    end
    in_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'hF);
    chk("flush_idle", 64'(idle), 64'd1);
    repeat (15) tick();
    chk("flush_no_ghosts", 64'(dut_pops[1] - base), 64'd0);
    lat_check(1, 32'h0000_1234);

`ifdef REMOTE_PIPE_STATS_EN
    // Stall counter on channel 3
    out_ready = 4'b0111;
    in_valid = 4'b1000;
    in_data[3*DW +: DW] = 32'h0000_0ABC;
    tick();
    in_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid[3]) seen = 1'b1;
      else tick();
    end
    chk("stats_valid_seen", 64'(seen), 64'd1);
    chk("stats_zero_start", 64'(stall_cnt), 64'd0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("stats_ch3", 64'(stall_cnt[3*32 +: 32]), 64'd12);
    chk("stats_others", 64'(stall_cnt[3*32-1:0]), 64'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("stats_flush_clear", 64'(stall_cnt == '0), 64'd1);
    tick();
    out_ready = '1;
`endif

    // Asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) begin
      in_valid = NC'($urandom);
      out_ready = NC'($urandom);
      for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = $urandom;
      tick();
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data_zero", 64'(out_data == '0), 64'd1);
    chk("arst_ready", 64'(in_ready), 64'hF);
    chk("arst_idle", 64'(idle), 64'd1);
`ifdef REMOTE_PIPE_STATS_EN
    chk("arst_stats", 64'(stall_cnt == '0), 64'd1);
`endif
    rst_pulses++;
    rst = 1'b0;
    in_valid = '0;
    tick();

    // Random traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      in_valid = NC'($urandom);
      for (int c = 0; c < NC; c++) begin
        out_ready[c] = ($urandom_range(0, 9) < 7);
        in_data[c*DW +: DW] = $urandom;
      end
      flush = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid = '0;
    flush = 1'b0;
    out_ready = '1;
    repeat (20) tick();
    @(negedge clk);
    chk("final_idle", 64'(idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/remote_latency_pipe.md
# remote_latency_pipe

Parametrised multi-channel, fixed-latency elastic pipeline for TeraPool remote-group TCDM traffic. It generalises the fixed `RemoteGroupLatencyCycle` delay into independent valid/ready channels, with configurable width, latency and buffering. Each channel uses credit-based backpressure, so it never drops or reorders beats. It sits between the sub-group interconnect and the remote-group ports, one instance per direction.

## Interface
- `NumChannels`, 4: number of independent channels.
- `DataWidth`, 32: payload width per channel, in bits.
- `LatencyCycles`, 7: fixed acceptance-to-output latency; must be ≥1.
- `FifoDepth`, `LatencyCycles+1`: per-channel credits and output-FIFO entries; must be ≥1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  synchronous flush of all channels.
- `in_valid_i`  in  NumChannels  per-channel input valid.
- `in_ready_o`  out  NumChannels  per-channel input ready.
- `in_data_i`  in  NumChannels×DataWidth  input payloads.
- `out_valid_o`  out  NumChannels  per-channel output valid.
- `out_ready_i`  in  NumChannels  per-channel output ready.
- `out_data_o`  out  NumChannels×DataWidth  output payloads.
- `idle_o`  out  1  high when no beat is in flight in any channel.
- `stall_cnt_o`  out  NumChannels×32  per-channel output-stall counters; present only with `REMOTE_PIPE_STATS_EN`.

## Operation
- Channels are fully independent, apart from the shared `flush_i` and `idle_o`.
- Each channel has three parts:
  - A delay line of `LatencyCycles` stages, carrying valid and data.
  - An output FIFO of `FifoDepth` entries.
  - A credit counter of width `$clog2(FifoDepth+1)`.
- Credits:
  - The counter resets to `FifoDepth`.
  - `in_ready_o[c] = (credits[c] != 0) && !flush_i`.
  - A beat is accepted when `in_valid_i[c] && in_ready_o[c]`. Acceptance consumes one credit.
  - An output pop (`out_valid_o[c] && out_ready_i[c]`) returns one credit.
  - If an accept and a pop happen in the same cycle, the count is unchanged.
  - Never underflow or overflow the counter; flag either in an assertion.
- Delay line and FIFO:
  - The delay line advances every cycle and never stalls.
  - The last stage writes into the FIFO.
  - Credits guarantee that delay-line beats plus FIFO entries never exceed `FifoDepth`, so a FIFO write can never hit a full FIFO. Assert this.
- Output:
  - `out_valid_o[c]` = FIFO not empty.
  - `out_data_o[c]` = FIFO head.
  - Beats leave in acceptance order.
  - Once `out_valid_o[c]` is asserted, it and `out_data_o[c]` hold stable until the pop.
- Flush:
  - On a cycle with `flush_i` high, at the next edge: clear all delay-line valids, empty all FIFOs, and restore credits to `FifoDepth`.
  - No input is accepted in the flush cycle.
  - Outputs offered in the flush cycle may be popped. That pop is still lost from credit accounting, because the credits are restored regardless.
- `idle_o` is high when, for every channel, credits equal `FifoDepth`.

## Timing
- Reset values while `rst_i` is high and immediately after it:
  - `out_valid_o = 0`, `out_data_o = 0`.
  - `in_ready_o` all 1.
  - `idle_o = 1`.
  - `stall_cnt_o = 0`.
  - FIFO pointers 0, all delay-line valids 0.
- Latency:
  - A beat accepted in cycle t has `out_valid_o` high in cycle t+`LatencyCycles`, provided its FIFO was empty.
  - If the FIFO was not empty, the beat appears after its predecessors have been popped.
- Throughput:
  - One beat per cycle per channel is sustained when `out_ready_i` is held high and `FifoDepth ≥ LatencyCycles+1`.
  - With a smaller `FifoDepth`, throughput is limited to `FifoDepth/(LatencyCycles+1)`.
- A returned credit becomes usable in the cycle after the pop.
- Asserting reset mid-operation drops all in-flight beats immediately and asynchronously.
- The FIFO read pointer and write pointer each wrap modulo `FifoDepth`; `FifoDepth` may be a non-power-of-2.

## Configuration
- `REMOTE_PIPE_STATS_EN` defined:
  - Each channel has a 32-bit counter that increments on every cycle with `out_valid_o[c] && !out_ready_i[c]`.
  - The counter saturates at `32'hFFFF_FFFF`.
  - It is cleared by reset and by `flush_i`.
  - It is exposed on `stall_cnt_o`.
- `REMOTE_PIPE_STATS_EN` undefined: the `stall_cnt_o` port and its counters are absent. All other behaviour is identical.

## Test plan
- Single beat: reset, then one beat `0xDEAD_BEEF` on channel 0 with `out_ready_i=1` → `out_valid_o[0]` pulses exactly at cycle t+7 carrying `0xDEAD_BEEF`. Other channels stay invalid. `idle_o` returns to 1 the cycle after the pop.
- Throughput: 100 back-to-back incrementing beats on all 4 channels with `out_ready_i` held at 1 → `in_ready_o` never drops, and the outputs are a contiguous in-order 0..99 stream starting at cycle 7.
- Backpressure: `out_ready_i[2]=0` while channel 2 streams → exactly 8 beats are accepted, then `in_ready_o[2]=0`. Release `out_ready_i[2]` → all 8 beats drain in order, and `in_ready_o[2]` rises one cycle after the first pop. No loss or duplication.
- Flush: pulse `flush_i` with 5 beats in flight on channel 1 → the next cycle shows `out_valid_o=0`, `in_ready_o` all 1, `idle_o=1`. None of the 5 beats ever appear. A fresh beat then has 7-cycle latency.
- Async reset: assert `rst_i` mid-stream for a sub-cycle pulse → outputs go to their reset values immediately, without waiting for a clock edge.
- Stats (with `REMOTE_PIPE_STATS_EN`): hold a valid beat on channel 3 with `out_ready_i[3]=0` for 12 cycles → `stall_cnt_o[3]=12`, and the other counters read 0. Flush → all counters read 0.
